lf_wide_add_seq: RTL and testbench



---
 rtl/lf_wide_add_seq_if.sv | 32 +++
 rtl/lf_wide_add_seq.sv | 77 +++++++
 tb/tb_lf_wide_add_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lf_wide_add_seq_if.sv
// Request/adder/result bundle for the multi-word add sequencer.
// slave is the sequencer side; master is whoever drives requests and hosts the adder.
interface lf_wide_add_seq_if #(
  parameter int W = 16,
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W*N-1:0] in_a;
  logic [W*N-1:0] in_b;
  logic           in_cin;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic           out_valid;
  logic           out_ready;
  logic [W*N-1:0] out_sum;
  logic           out_cout;
  logic           busy;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/lf_wide_add_seq.sv
// Serialises a W*N-bit add onto a W-bit adder, LS chunk first, chaining carries,
// and returns the registered wide sum over valid/ready.
module lf_wide_add_seq #(
  parameter int W         = 16,
  parameter int N         = 4,
  parameter int ADDER_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  lf_wide_add_seq_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (ADDER_LAT > 0) ? $clog2(ADDER_LAT + 1) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(N - 1);
  localparam logic [CW-1:0] LAST_W = CW'(ADDER_LAT);

  logic [1:0]     state;
  logic [W*N-1:0] a_q, b_q, sum_q;
  logic           carry, cout_q;
  logic [KW-1:0]  k;
  logic [CW-1:0]  wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      k      <= '0;
      wcnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          a_q   <= bus.in_a;
          b_q   <= bus.in_b;
          carry <= bus.in_cin;
          k     <= '0;
          wcnt  <= '0;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          // Operands held for ADDER_LAT+1 cycles; result sampled on the last edge.
          if (wcnt == LAST_W) begin
            wcnt               <= '0;
            sum_q[k*W +: W]    <= bus.add_sum;
            carry              <= bus.add_cout;
            if (k == LAST_K) begin
              cout_q <= bus.add_cout;
              state  <= S_DONE;
            end else begin
              k <= k + KW'(1);
            end
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.add_a     = (state == S_ISSUE) ? a_q[k*W +: W] : '0;
  assign bus.add_b     = (state == S_ISSUE) ? b_q[k*W +: W] : '0;
  assign bus.add_cin   = (state == S_ISSUE) ? carry : 1'b0;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
endmodule

// File: tb/tb_lf_wide_add_seq.sv
// Bench for lf_wide_add_seq: hosts a 1-cycle 16-bit adder model and checks
// wide sums, per-chunk carries, timing and handshake rules against plain arithmetic.
module tb_lf_wide_add_seq;
  localparam int W = 16;
  localparam int N = 4;
  localparam int LAT = 1;
  localparam int CP = LAT + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  lf_wide_add_seq_if #(.W(W), .N(N)) bus ();

  lf_wide_add_seq #(.W(W), .N(N), .ADDER_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered adder standing in for LFadder (latency 1).
  always_ff @(posedge clk)
    {bus.add_cout, bus.add_sum} <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + 17'(bus.add_cin);

  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + 65'(c);
  endfunction

  // Carry entering chunk k: carry out of the low k*W bits of the addition.
  function automatic logic ref_cin(input logic [63:0] a, input logic [63:0] b, input logic c, input int k);
    logic [64:0] m, t;
    if (k == 0) return c;
    m = (65'd1 << (k * W)) - 65'd1;
    t = ({1'b0, a} & m) + ({1'b0, b} & m) + 65'(c);
    return t[k*W];
  endfunction

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                        output logic [63:0] s, output logic co, output int lat,
                        output logic [3:0] cins);
    int g;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_cin = c;
    g = 0;
    while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = -1; cins = '0;
    for (int j = 0; j < 40; j++) begin
      if (bus.out_valid) begin lat = j; break; end
      if (j % CP == 0 && j < N * CP) cins[j / CP] = bus.add_cin;
      @(negedge clk);
    end
    s = bus.out_sum; co = bus.out_cout;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_valid_busy got %b%b want 00", bus.out_valid, bus.busy); end
    n_cmp++; if (bus.out_sum !== 64'd0 || bus.out_cout !== 1'b0) begin n_err++; $display("FAIL reset_out got %h/%b want 0/0", bus.out_sum, bus.out_cout); end
    n_cmp++; if (bus.add_a !== 16'd0 || bus.add_b !== 16'd0 || bus.add_cin !== 1'b0) begin n_err++; $display("FAIL reset_add got %h %h %b want 0", bus.add_a, bus.add_b, bus.add_cin); end
    rst_n = 1'b1;
  endtask

  task automatic test_carry_cross;
    logic [63:0] s; logic co; int lat; logic [3:0] ci;
    bus.out_ready = 1'b1;
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, s, co, lat, ci);
    n_cmp++; if (s !== 64'h0000_0000_0001_0000 || co !== 1'b0) begin n_err++; $display("FAIL carry_cross_sum got %h/%b want 0000000000010000/0", s, co); end
    n_cmp++; if (ci !== 4'b0010) begin n_err++; $display("FAIL carry_cross_cins got %b want 0010", ci); end
  endtask

  task automatic test_max;
    logic [63:0] s; logic co; int lat; logic [3:0] ci;
    run_op('1, '1, 1'b1, s, co, lat, ci);
    n_cmp++; if (s !== 64'hFFFF_FFFF_FFFF_FFFF || co !== 1'b1) begin n_err++; $display("FAIL max_sum got %h/%b want ffffffffffffffff/1", s, co); end
  endtask

  task automatic test_ripple;
    logic [63:0] s; logic co; int lat; logic [3:0] ci;
    run_op('1, 64'd0, 1'b1, s, co, lat, ci);
    n_cmp++; if (s !== 64'd0 || co !== 1'b1) begin n_err++; $display("FAIL ripple_sum got %h/%b want 0/1", s, co); end
    n_cmp++; if (ci !== 4'b1111) begin n_err++; $display("FAIL ripple_cins got %b want 1111", ci); end
    n_cmp++; if (lat !== N * CP) begin n_err++; $display("FAIL ripple_latency got %0d want %0d", lat, N * CP); end
  endtask

  task automatic test_random;
    logic [63:0] a, b, s; logic c, co; int lat; logic [3:0] ci, eci; logic [64:0] e;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = 1'($urandom);
      if (i % 4 == 1) b = ~a;  // long carry chains
      e = ref_add(a, b, c);
      for (int k = 0; k < N; k++) eci[k] = ref_cin(a, b, c, k);
      run_op(a, b, c, s, co, lat, ci);
      n_cmp++; if ({co, s} !== e) begin n_err++; $display("FAIL random_sum[%0d] got %b_%h want %h", i, co, s, e); end
      n_cmp++; if (ci !== eci) begin n_err++; $display("FAIL random_cins[%0d] got %b want %b", i, ci, eci); end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] qa[$], qb[$]; logic qc[$];
    logic [64:0] e; logic prev_ov, renew; int acc, hs, ndone;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.in_a = {$urandom, $urandom}; bus.in_b = {$urandom, $urandom}; bus.in_cin = 1'($urandom);
    prev_ov = 1'b0; renew = 1'b0; acc = -100; hs = -100; ndone = 0;
    for (int t = 0; t < 60 && ndone < 4; t++) begin
      @(negedge clk);
      if (renew) begin
        bus.in_a = {$urandom, $urandom}; bus.in_b = {$urandom, $urandom}; bus.in_cin = 1'($urandom);
        renew = 1'b0;
      end
      if (bus.out_valid && !prev_ov) begin
        n_cmp++; if (cyc - acc !== N * CP) begin n_err++; $display("FAIL b2b_latency got %0d want %0d", cyc - acc, N * CP); end
      end
      if (bus.out_valid) begin
        hs = cyc + 1;
        if (qa.size() > 0) begin
          e = ref_add(qa.pop_front(), qb.pop_front(), qc.pop_front());
          n_cmp++; if ({bus.out_cout, bus.out_sum} !== e) begin n_err++; $display("FAIL b2b_sum got %b_%h want %h", bus.out_cout, bus.out_sum, e); end
        end
        ndone++;
      end
      if (bus.in_ready) begin
        if (hs > 0) begin
          n_cmp++; if (cyc + 1 !== hs + 1) begin n_err++; $display("FAIL b2b_reaccept got edge %0d want %0d", cyc + 1, hs + 1); end
        end
        acc = cyc + 1;
        qa.push_back(bus.in_a); qb.push_back(bus.in_b); qc.push_back(bus.in_cin);
        renew = 1'b1;
      end
      prev_ov = bus.out_valid;
    end
    n_cmp++; if (ndone < 4) begin n_err++; $display("FAIL b2b_timeout got %0d results want 4", ndone); end
    @(negedge clk); bus.in_valid = 1'b0;
    while (bus.busy) @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [63:0] s, snap; logic co; int lat; logic [3:0] ci; logic [64:0] e;
    logic [63:0] a, b;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    e = ref_add(a, b, 1'b0);
    bus.out_ready = 1'b0;
    run_op(a, b, 1'b0, s, co, lat, ci);
    n_cmp++; if ({co, s} !== e || lat !== N * CP) begin n_err++; $display("FAIL bp_result got %b_%h lat %0d want %h lat %0d", co, s, lat, e, N * CP); end
    snap = s;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0); bus.in_a = {$urandom, $urandom}; bus.in_b = ~bus.in_a;
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== snap) begin
        n_err++; $display("FAIL bp_hold[%0d] got v%b r%b %h want v1 r0 %h", i, bus.out_valid, bus.in_ready, bus.out_sum, snap);
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got v%b r%b want v0 r1", bus.out_valid, bus.in_ready); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_no_extra got busy %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] s; logic co; int lat; logic [3:0] ci; int seen;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = '1; bus.in_b = 64'h1234; bus.in_cin = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2 * CP) @(negedge clk);  // now driving chunk 2
    n_cmp++; if (bus.add_a !== 16'hFFFF) begin n_err++; $display("FAIL rst_mid_pre got add_a %h want ffff", bus.add_a); end
    rst_n = 1'b0; #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_state got r%b v%b b%b want r1 v0 b0", bus.in_ready, bus.out_valid, bus.busy); end
    n_cmp++; if (bus.add_a !== 16'd0 || bus.add_b !== 16'd0 || bus.add_cin !== 1'b0 || bus.out_sum !== 64'd0) begin n_err++; $display("FAIL rst_mid_regs got %h %h %b %h want 0", bus.add_a, bus.add_b, bus.add_cin, bus.out_sum); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (bus.out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_mid_no_valid got %0d cycles want 0", seen); end
    run_op(64'h8000_0000_0000_0001, 64'h8000_0000_0000_FFFF, 1'b0, s, co, lat, ci);
    n_cmp++; if ({co, s} !== ref_add(64'h8000_0000_0000_0001, 64'h8000_0000_0000_FFFF, 1'b0)) begin n_err++; $display("FAIL rst_mid_after got %b_%h", co, s); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_carry_cross();
    test_max();
    test_ripple();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
